// File: rtl/ppe_req_tracker.sv
// Pending-request bitmap for the priority encoder: indexed set/clear, incremental count, empty/full.
// Optional sticky error flags err_dup/err_spur are built only when PPE_REQ_TRACKER_ERR_EN is defined.
module ppe_req_tracker #(
    parameter int W  = 1024,
    parameter int IW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_vld,
    input  logic [IW-1:0] set_idx,
    input  logic          clr_vld,
    input  logic [IW-1:0] clr_idx,
    input  logic          flush,
    output logic [W-1:0]  req_vec,
    output logic [IW:0]   pend_cnt,
    output logic          empty,
    output logic          full,
    output logic          err_dup,
    output logic          err_spur
);

    localparam logic [IW:0] W_L = (IW+1)'(W);

    logic [W-1:0]  req_q, req_d;
    logic [IW:0]   cnt_q, cnt_d;
    logic          empty_q, full_q;
    logic [W-1:0]  set_mask, clr_mask;
    logic          set_ok, clr_ok;
    logic          set_hit, clr_hit;
    logic          set_pend, clr_pend;
    logic          same_idx, inc, dec;

    // Out-of-range indices only exist when W is not a power of two of IW.
    if (W == (1 << IW)) begin : g_idx_full
        assign set_ok = 1'b1;
        assign clr_ok = 1'b1;
    end else begin : g_idx_part
        assign set_ok = ({1'b0, set_idx} < W_L);
        assign clr_ok = ({1'b0, clr_idx} < W_L);
    end

    always_comb begin
        set_hit  = set_vld && set_ok;
        clr_hit  = clr_vld && clr_ok;
        set_mask = '0;
        clr_mask = '0;
        set_pend = 1'b0;
        clr_pend = 1'b0;
        if (set_ok) set_pend = req_q[set_idx];
        if (clr_ok) clr_pend = req_q[clr_idx];
        if (set_hit) set_mask[set_idx] = 1'b1;
        if (clr_hit) clr_mask[clr_idx] = 1'b1;
        same_idx = set_hit && clr_hit && (set_idx == clr_idx);
        // A same-cycle serve-and-re-request counts as +1 -1 on a pending bit.
        inc = set_hit && (!set_pend || same_idx);
        dec = clr_hit && clr_pend;
        if (flush) begin
            req_d = '0;
            cnt_d = '0;
        end else begin
            req_d = (req_q & ~clr_mask) | set_mask;
            cnt_d = cnt_q + {{IW{1'b0}}, inc} - {{IW{1'b0}}, dec};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == W_L);
        end
    end

    assign req_vec  = req_q;
    assign pend_cnt = cnt_q;
    assign empty    = empty_q;
    assign full     = full_q;

`ifdef PPE_REQ_TRACKER_ERR_EN
    logic dup_q, spur_q;
    logic dup_raise, spur_raise;

    assign dup_raise  = !flush && set_hit && set_pend && !same_idx;
    assign spur_raise = !flush && clr_vld && (!clr_ok || !clr_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dup_q  <= 1'b0;
            spur_q <= 1'b0;
        end else begin
            dup_q  <= dup_q  | dup_raise;
            spur_q <= spur_q | spur_raise;
        end
    end

    assign err_dup  = dup_q;
    assign err_spur = spur_q;
`else
    assign err_dup  = 1'b0;
    assign err_spur = 1'b0;
`endif

endmodule

// File: tb/tb_ppe_req_tracker.sv
// Directed self-checking bench for ppe_req_tracker (W=1024, IW=10).
module tb_ppe_req_tracker;

    localparam int W  = 1024;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_vld;
    logic [IW-1:0] set_idx;
    logic          clr_vld;
    logic [IW-1:0] clr_idx;
    logic          flush;
    logic [W-1:0]  req_vec;
    logic [IW:0]   pend_cnt;
    logic          empty;
    logic          full;
    logic          err_dup;
    logic          err_spur;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_vec;

    ppe_req_tracker #(.W(W), .IW(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_vld  (set_vld),
        .set_idx  (set_idx),
        .clr_vld  (clr_vld),
        .clr_idx  (clr_idx),
        .flush    (flush),
        .req_vec  (req_vec),
        .pend_cnt (pend_cnt),
        .empty    (empty),
        .full     (full),
        .err_dup  (err_dup),
        .err_spur (err_spur)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus; outputs are sampled 1ns after the edge.
    task automatic drive(input logic sv, input int si, input logic cv, input int ci, input logic fl);
        set_vld = sv;
        set_idx = IW'(si);
        clr_vld = cv;
        clr_idx = IW'(ci);
        flush   = fl;
        @(posedge clk);
        #1;
        set_vld = 1'b0;
        clr_vld = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic do_set(input int idx);
        drive(1'b1, idx, 1'b0, 0, 1'b0);
    endtask

    task automatic do_clr(input int idx);
        drive(1'b0, 0, 1'b1, idx, 1'b0);
    endtask

    task automatic do_flush();
        drive(1'b0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_vld = 1'b0; set_idx = '0; clr_vld = 1'b0; clr_idx = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_vec !== '0) begin errors++; $display("FAIL reset_vec got %h exp 0", req_vec); end
        checks++; if (pend_cnt !== 11'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", pend_cnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if ({err_dup, err_spur} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {err_dup, err_spur}); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_set_basic();
        do_set(5);
        exp_vec = '0; exp_vec[5] = 1'b1;
        checks++; if (req_vec !== exp_vec) begin errors++; $display("FAIL set5_vec got %h exp %h", req_vec, exp_vec); end
        checks++; if (pend_cnt !== 11'd1) begin errors++; $display("FAIL set5_cnt got %0d exp 1", pend_cnt); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL set5_empty got %b exp 0", empty); end
        do_set(1023);
        do_set(0);
        exp_vec[1023] = 1'b1; exp_vec[0] = 1'b1;
        checks++; if (req_vec !== exp_vec) begin errors++; $display("FAIL set3_vec got %h exp %h", req_vec, exp_vec); end
        checks++; if (pend_cnt !== 11'd3) begin errors++; $display("FAIL set3_cnt got %0d exp 3", pend_cnt); end
        // Idle cycle: state holds.
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (pend_cnt !== 11'd3) begin errors++; $display("FAIL idle_cnt got %0d exp 3", pend_cnt); end
    endtask

    task automatic test_clear();
        // Pending {0,5,1023} from the previous test.
        do_clr(5);
        exp_vec = '0; exp_vec[0] = 1'b1; exp_vec[1023] = 1'b1;
        checks++; if (req_vec !== exp_vec) begin errors++; $display("FAIL clr5_vec got %h exp %h", req_vec, exp_vec); end
        checks++; if (pend_cnt !== 11'd2) begin errors++; $display("FAIL clr5_cnt got %0d exp 2", pend_cnt); end
        do_clr(5);
        checks++; if (pend_cnt !== 11'd2) begin errors++; $display("FAIL clr_nonpend_cnt got %0d exp 2", pend_cnt); end
        do_set(0);
        checks++; if (pend_cnt !== 11'd2) begin errors++; $display("FAIL set_idem_cnt got %0d exp 2", pend_cnt); end
        do_clr(0);
        do_clr(1023);
        checks++; if (req_vec !== '0) begin errors++; $display("FAIL clr_all_vec got %h exp 0", req_vec); end
        checks++; if (empty !== 1'b1 || pend_cnt !== 11'd0) begin errors++; $display("FAIL clr_all_empty got %b/%0d exp 1/0", empty, pend_cnt); end
    endtask

    task automatic test_same_idx();
        do_flush();
        do_set(7);
        drive(1'b1, 7, 1'b1, 7, 1'b0);
        exp_vec = '0; exp_vec[7] = 1'b1;
        checks++; if (req_vec !== exp_vec) begin errors++; $display("FAIL same7_vec got %h exp %h", req_vec, exp_vec); end
        checks++; if (pend_cnt !== 11'd1) begin errors++; $display("FAIL same7_cnt got %0d exp 1", pend_cnt); end
        // Same index, bit not pending: ends set, count +1.
        drive(1'b1, 8, 1'b1, 8, 1'b0);
        exp_vec[8] = 1'b1;
        checks++; if (req_vec !== exp_vec) begin errors++; $display("FAIL same8_vec got %h exp %h", req_vec, exp_vec); end
        checks++; if (pend_cnt !== 11'd2) begin errors++; $display("FAIL same8_cnt got %0d exp 2", pend_cnt); end
        // Different indices in one cycle: set 9, clear 7.
        drive(1'b1, 9, 1'b1, 7, 1'b0);
        exp_vec[7] = 1'b0; exp_vec[9] = 1'b1;
        checks++; if (req_vec !== exp_vec) begin errors++; $display("FAIL setclr_vec got %h exp %h", req_vec, exp_vec); end
        checks++; if (pend_cnt !== 11'd2) begin errors++; $display("FAIL setclr_cnt got %0d exp 2", pend_cnt); end
    endtask

    task automatic test_full();
        do_flush();
        for (int i = 0; i < W; i++) do_set(i);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", full); end
        checks++; if (pend_cnt !== 11'd1024) begin errors++; $display("FAIL full_cnt got %0d exp 1024", pend_cnt); end
        checks++; if (req_vec !== {W{1'b1}}) begin errors++; $display("FAIL full_vec got %h exp all ones", req_vec); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", empty); end
        do_clr(512);
        exp_vec = {W{1'b1}}; exp_vec[512] = 1'b0;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL unfull_flag got %b exp 0", full); end
        checks++; if (pend_cnt !== 11'd1023) begin errors++; $display("FAIL unfull_cnt got %0d exp 1023", pend_cnt); end
        checks++; if (req_vec !== exp_vec) begin errors++; $display("FAIL unfull_vec got %h exp %h", req_vec, exp_vec); end
    endtask

    task automatic test_flush();
        do_flush();
        do_set(3);
        do_set(9);
        checks++; if (pend_cnt !== 11'd2) begin errors++; $display("FAIL preflush_cnt got %0d exp 2", pend_cnt); end
        drive(1'b1, 4, 1'b1, 3, 1'b1);
        checks++; if (req_vec !== '0) begin errors++; $display("FAIL flush_vec got %h exp 0", req_vec); end
        checks++; if (pend_cnt !== 11'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", pend_cnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
    endtask

    task automatic test_async_reset();
        do_set(11);
        do_set(12);
        #2;
        rst = 1'b1;
        #1;
        // Still between clock edges: reset must act without a clock.
        checks++; if (req_vec !== '0 || pend_cnt !== 11'd0) begin errors++; $display("FAIL async_rst got %h/%0d exp 0/0", req_vec, pend_cnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_rst_empty got %b exp 1", empty); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_errors();
        pulse_rst();
`ifdef PPE_REQ_TRACKER_ERR_EN
        do_clr(100);
        checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL spur_raise got %b exp 1", err_spur); end
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL spur_nodup got %b exp 0", err_dup); end
        drive(1'b0, 0, 1'b0, 0, 1'b0);
        checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", err_spur); end
        do_set(2);
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL dup_first got %b exp 0", err_dup); end
        do_set(2);
        checks++; if (err_dup !== 1'b1) begin errors++; $display("FAIL dup_raise got %b exp 1", err_dup); end
        pulse_rst();
        checks++; if ({err_dup, err_spur} !== 2'b00) begin errors++; $display("FAIL err_rst got %b exp 00", {err_dup, err_spur}); end
        // Same-index serve-and-re-request is not a duplicate.
        do_set(6);
        drive(1'b1, 6, 1'b1, 6, 1'b0);
        checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL dup_sameidx got %b exp 0", err_dup); end
        // Flush cycle suppresses both flags.
        drive(1'b1, 6, 1'b1, 200, 1'b1);
        checks++; if ({err_dup, err_spur} !== 2'b00) begin errors++; $display("FAIL err_flush got %b exp 00", {err_dup, err_spur}); end
`else
        do_clr(100);
        do_set(2);
        do_set(2);
        checks++; if ({err_dup, err_spur} !== 2'b00) begin errors++; $display("FAIL err_tied got %b exp 00", {err_dup, err_spur}); end
`endif
    endtask

    initial begin
        test_reset();
        test_set_basic();
        test_clear();
        test_same_idx();
        test_full();
        test_flush();
        test_async_reset();
        test_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
